// File: rtl/frame_sync_pkg.sv
// ============================================================================
// frame_sync_pkg : state encodings and link defaults for the frame synchroniser
// Rev 1.0
// ============================================================================
`default_nettype none

package frame_sync_pkg;

    localparam logic [2:0] ST_HUNT     = 3'b000;
    localparam logic [2:0] ST_FLYWHEEL = 3'b001;
    localparam logic [2:0] ST_LOCK     = 3'b010;
    localparam logic [2:0] ST_VERIFY   = 3'b011;

    localparam int         DEFAULT_SYNC_LEN  = 8;
    localparam logic [7:0] DEFAULT_SYNC_WORD = 8'h7E;
    localparam int         DEFAULT_FRAME_LEN = 64;

    function automatic logic [7:0] sat_inc8(input logic [7:0] value);
        return (value == 8'hFF) ? value : value + 8'd1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/sync_word_matcher.sv
// ============================================================================
// sync_word_matcher : Hamming-distance compare of a window against a sync word
// Rev 1.0
// ============================================================================
`default_nettype none

module sync_word_matcher #(
    parameter int                  SYNC_LEN  = 8,
    parameter logic [SYNC_LEN-1:0] SYNC_WORD = 8'h7E,
    parameter int                  MAX_ERR   = 0
) (
    input  logic [SYNC_LEN-1:0] window,
    output logic                match
);

    localparam int ERR_W = $clog2(SYNC_LEN + 1);

    logic [SYNC_LEN-1:0] w_diff;
    logic [ERR_W-1:0]    w_err;

    assign w_diff = window ^ SYNC_WORD;

    always_comb begin
        w_err = '0;
        for (int i = 0; i < SYNC_LEN; i++) begin
            w_err = w_err + ERR_W'(w_diff[i]);
        end
    end

    assign match = (w_err <= ERR_W'(MAX_ERR));

endmodule

`default_nettype wire

// File: rtl/frame_sync_param.sv
// ============================================================================
// frame_sync_param : serial frame synchroniser with hunt/verify/lock/flywheel
// Rev 1.0
// ============================================================================
`default_nettype none

module frame_sync_param
    import frame_sync_pkg::*;
#(
    parameter int                  SYNC_LEN  = DEFAULT_SYNC_LEN,
    parameter logic [SYNC_LEN-1:0] SYNC_WORD = SYNC_LEN'(DEFAULT_SYNC_WORD),
    parameter int                  FRAME_LEN = DEFAULT_FRAME_LEN,
    parameter int                  BACK_N    = 2,
    parameter int                  FWD_N     = 2,
    parameter int                  MAX_ERR   = 0,
    parameter int                  CNT_W     = $clog2(FRAME_LEN)
) (
    input  logic       clk_out,
    input  logic       rst,
    input  logic       data_in,
    input  logic       data_valid,
    output logic       is_frame_synchronized,
    output logic [2:0] synchronizer_state,
    output logic       data_sync_out,
    output logic       frame_start,
    output logic [7:0] lock_loss_cnt
);

    logic [SYNC_LEN-1:0] r_buf;
    logic [2:0]          r_state;
    logic [CNT_W-1:0]    r_bit_cnt;
    logic [2:0]          r_hit_cnt;
    logic [2:0]          r_miss_cnt;
    logic [7:0]          r_loss_cnt;
    logic                r_data_sync;
    logic                r_frame_start;

    logic                w_match;
    logic                w_checkpoint;
    logic                w_accept;
    logic [2:0]          w_state_nxt;
    logic [CNT_W-1:0]    w_cnt_nxt;
    logic [2:0]          w_hit_nxt;
    logic [2:0]          w_hit_inc;
    logic [2:0]          w_miss_nxt;
    logic [2:0]          w_miss_inc;
    logic [7:0]          w_loss_nxt;

    sync_word_matcher #(
        .SYNC_LEN  (SYNC_LEN),
        .SYNC_WORD (SYNC_WORD),
        .MAX_ERR   (MAX_ERR)
    ) u_matcher (
        .window (r_buf),
        .match  (w_match)
    );

    // Outside HUNT only the bit at the frame boundary may judge the sync word.
    assign w_checkpoint = data_valid && (r_state != ST_HUNT) &&
                          (r_bit_cnt == CNT_W'(FRAME_LEN - 1));
    assign w_hit_inc    = r_hit_cnt + 3'd1;
    assign w_miss_inc   = r_miss_cnt + 3'd1;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_bit_cnt;
        w_hit_nxt   = r_hit_cnt;
        w_miss_nxt  = r_miss_cnt;
        w_loss_nxt  = r_loss_cnt;
        w_accept    = 1'b0;
        if (data_valid) begin
            if ((r_state == ST_HUNT) || w_checkpoint) begin
                w_cnt_nxt = '0;
            end else begin
                w_cnt_nxt = r_bit_cnt + 1'b1;
            end
            case (r_state)
                ST_HUNT: begin
                    if (w_match) begin
                        w_accept    = 1'b1;
                        w_hit_nxt   = 3'd1;
                        w_state_nxt = (BACK_N == 1) ? ST_LOCK : ST_VERIFY;
                    end
                end
                ST_VERIFY: begin
                    if (w_checkpoint && w_match) begin
                        w_accept  = 1'b1;
                        w_hit_nxt = w_hit_inc;
                        if (w_hit_inc == 3'(BACK_N)) begin
                            w_state_nxt = ST_LOCK;
                        end
                    end else if (w_checkpoint) begin
                        w_hit_nxt   = '0;
                        w_state_nxt = ST_HUNT;
                    end
                end
                ST_LOCK: begin
                    if (w_checkpoint && w_match) begin
                        w_accept = 1'b1;
                    end else if (w_checkpoint) begin
                        if (FWD_N == 1) begin
                            w_state_nxt = ST_HUNT;
                            w_hit_nxt   = '0;
                            w_loss_nxt  = sat_inc8(r_loss_cnt);
                        end else begin
                            w_miss_nxt  = 3'd1;
                            w_state_nxt = ST_FLYWHEEL;
                        end
                    end
                end
                ST_FLYWHEEL: begin
                    if (w_checkpoint && w_match) begin
                        w_accept    = 1'b1;
                        w_miss_nxt  = '0;
                        w_state_nxt = ST_LOCK;
                    end else if (w_checkpoint) begin
                        if (w_miss_inc == 3'(FWD_N)) begin
                            w_miss_nxt  = '0;
                            w_hit_nxt   = '0;
                            w_state_nxt = ST_HUNT;
                            w_loss_nxt  = sat_inc8(r_loss_cnt);
                        end else begin
                            w_miss_nxt = w_miss_inc;
                        end
                    end
                end
                default: begin
                    w_state_nxt = ST_HUNT;
                    w_hit_nxt   = '0;
                    w_miss_nxt  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_out or posedge rst) begin
        if (rst) begin
            r_buf         <= '0;
            r_state       <= ST_HUNT;
            r_bit_cnt     <= '0;
            r_hit_cnt     <= '0;
            r_miss_cnt    <= '0;
            r_loss_cnt    <= '0;
            r_data_sync   <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            // The strobe is a single-cycle pulse even if data_valid drops next.
            r_frame_start <= w_accept;
            if (data_valid) begin
                r_buf       <= {r_buf[SYNC_LEN-2:0], data_in};
                r_data_sync <= r_buf[SYNC_LEN-1];
                r_state     <= w_state_nxt;
                r_bit_cnt   <= w_cnt_nxt;
                r_hit_cnt   <= w_hit_nxt;
                r_miss_cnt  <= w_miss_nxt;
                r_loss_cnt  <= w_loss_nxt;
            end
        end
    end

    assign is_frame_synchronized = (r_state == ST_LOCK) || (r_state == ST_FLYWHEEL);
    assign synchronizer_state    = r_state;
    assign data_sync_out         = r_data_sync;
    assign frame_start           = r_frame_start;
    assign lock_loss_cnt         = r_loss_cnt;

endmodule

`default_nettype wire

// File: tb/tb_frame_sync_param.sv
// ============================================================================
// tb_frame_sync_param : three parameterisations driven by one bit stream
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_frame_sync_param;
    import frame_sync_pkg::*;

    localparam int         NDUT = 3;
    localparam int         SL   = DEFAULT_SYNC_LEN;
    localparam int         FL   = DEFAULT_FRAME_LEN;
    localparam logic [7:0] SW   = DEFAULT_SYNC_WORD;

    logic       clk;
    logic       rst;
    logic       data_in;
    logic       data_valid;
    logic       sync_o [NDUT];
    logic [2:0] st_o   [NDUT];
    logic       dso_o  [NDUT];
    logic       fs_o   [NDUT];
    logic [7:0] loss_o [NDUT];

    int p_back [NDUT] = '{2, 2, 3};
    int p_fwd  [NDUT] = '{2, 2, 1};
    int p_err  [NDUT] = '{0, 1, 0};

    logic [2:0] m_state  [NDUT];
    int         m_hits   [NDUT];
    int         m_miss   [NDUT];
    int         m_anchor [NDUT];
    int         m_loss   [NDUT];
    logic       m_fs     [NDUT];
    bit         hist [$];

    int n_checks = 0;
    int n_pass   = 0;

    frame_sync_param u_dut0 (
        .clk_out(clk), .rst(rst), .data_in(data_in), .data_valid(data_valid),
        .is_frame_synchronized(sync_o[0]), .synchronizer_state(st_o[0]),
        .data_sync_out(dso_o[0]), .frame_start(fs_o[0]), .lock_loss_cnt(loss_o[0])
    );

    frame_sync_param #(.MAX_ERR(1)) u_dut1 (
        .clk_out(clk), .rst(rst), .data_in(data_in), .data_valid(data_valid),
        .is_frame_synchronized(sync_o[1]), .synchronizer_state(st_o[1]),
        .data_sync_out(dso_o[1]), .frame_start(fs_o[1]), .lock_loss_cnt(loss_o[1])
    );

    frame_sync_param #(.BACK_N(3), .FWD_N(1)) u_dut2 (
        .clk_out(clk), .rst(rst), .data_in(data_in), .data_valid(data_valid),
        .is_frame_synchronized(sync_o[2]), .synchronizer_state(st_o[2]),
        .data_sync_out(dso_o[2]), .frame_start(fs_o[2]), .lock_loss_cnt(loss_o[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        for (int k = 0; k < NDUT; k++) begin
            m_state[k]  = ST_HUNT;
            m_hits[k]   = 0;
            m_miss[k]   = 0;
            m_anchor[k] = 0;
            m_loss[k]   = 0;
            m_fs[k]     = 1'b0;
        end
        hist.delete();
    endtask

    // Frame boundaries are every FL accepted bits after the capturing bit.
    task automatic model_step(input logic d);
        int         n;
        logic [7:0] win;
        bit         good;
        n = hist.size();
        for (int i = 0; i < SL; i++) begin
            win[SL-1-i] = 1'b0;
            if (n - SL + i >= 0) win[SL-1-i] = hist[n-SL+i];
        end
        for (int k = 0; k < NDUT; k++) begin
            good = ($countones(win ^ SW) <= p_err[k]);
            if (m_state[k] == ST_HUNT) begin
                if (good) begin
                    m_anchor[k] = n;
                    m_hits[k]   = 1;
                    m_fs[k]     = 1'b1;
                    m_state[k]  = (p_back[k] == 1) ? ST_LOCK : ST_VERIFY;
                end
            end else if ((n - m_anchor[k]) % FL == 0) begin
                if (good) begin
                    m_fs[k] = 1'b1;
                    if (m_state[k] == ST_VERIFY) begin
                        m_hits[k]++;
                        if (m_hits[k] == p_back[k]) m_state[k] = ST_LOCK;
                    end else begin
                        m_miss[k]  = 0;
                        m_state[k] = ST_LOCK;
                    end
                end else if (m_state[k] == ST_VERIFY) begin
                    m_hits[k]  = 0;
                    m_state[k] = ST_HUNT;
                end else begin
                    m_miss[k]++;
                    if (m_miss[k] == p_fwd[k]) begin
                        m_miss[k]  = 0;
                        m_hits[k]  = 0;
                        m_state[k] = ST_HUNT;
                        m_loss[k]  = (m_loss[k] < 255) ? m_loss[k] + 1 : 255;
                    end else begin
                        m_state[k] = ST_FLYWHEEL;
                    end
                end
            end
        end
        hist.push_back(d);
    endtask

    task automatic compare_all();
        int   n;
        logic exp_dso;
        n = hist.size();
        exp_dso = 1'b0;
        if (n >= SL + 1) exp_dso = hist[n-SL-1];
        for (int k = 0; k < NDUT; k++) begin
            chk($sformatf("dut%0d.state", k), 32'(st_o[k]), 32'(m_state[k]));
            chk($sformatf("dut%0d.sync", k), 32'(sync_o[k]),
                32'((m_state[k] == ST_LOCK) || (m_state[k] == ST_FLYWHEEL)));
            chk($sformatf("dut%0d.dso", k), 32'(dso_o[k]), 32'(exp_dso));
            chk($sformatf("dut%0d.fstart", k), 32'(fs_o[k]), 32'(m_fs[k]));
            chk($sformatf("dut%0d.loss", k), 32'(loss_o[k]), 32'(m_loss[k]));
        end
    endtask

    task automatic tick(input logic d, input logic v);
        data_in    = d;
        data_valid = v;
        @(posedge clk);
        for (int k = 0; k < NDUT; k++) m_fs[k] = 1'b0;
        if (v) model_step(d);
        @(negedge clk);
        compare_all();
    endtask

    // Payload has a zero every third bit so no payload window resembles the sync word.
    task automatic send_frame(input logic [7:0] sw, input int gap_pct, input int nbits);
        logic b;
        for (int i = 0; i < nbits; i++) begin
            if (gap_pct > 0 && int'($urandom_range(0, 99)) < gap_pct)
                tick(1'($urandom_range(0, 1)), 1'b0);
            if (i < SL)                 b = sw[SL-1-i];
            else if ((i - SL) % 3 == 0) b = 1'b0;
            else                        b = 1'($urandom_range(0, 1));
            tick(b, 1'b1);
        end
    endtask

    task automatic async_reset_check();
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        for (int k = 0; k < NDUT; k++) begin
            chk($sformatf("areset.dut%0d.state", k), 32'(st_o[k]), 32'(ST_HUNT));
            chk($sformatf("areset.dut%0d.sync", k), 32'(sync_o[k]), 32'd0);
            chk($sformatf("areset.dut%0d.dso", k), 32'(dso_o[k]), 32'd0);
            chk($sformatf("areset.dut%0d.fstart", k), 32'(fs_o[k]), 32'd0);
            chk($sformatf("areset.dut%0d.loss", k), 32'(loss_o[k]), 32'd0);
        end
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst        = 1'b1;
        data_in    = 1'b0;
        data_valid = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        compare_all();
        rst = 1'b0;

        // Clean acquisition
        send_frame(SW, 0, FL);
        chk("p1.f1.dut0", 32'(st_o[0]), 32'(ST_VERIFY));
        chk("p1.f1.dut2", 32'(st_o[2]), 32'(ST_VERIFY));
        send_frame(SW, 0, FL);
        chk("p1.f2.dut0", 32'(st_o[0]), 32'(ST_LOCK));
        chk("p1.f2.sync0", 32'(sync_o[0]), 32'd1);
        chk("p1.f2.dut2", 32'(st_o[2]), 32'(ST_VERIFY));
        send_frame(SW, 0, FL);
        chk("p1.f3.dut0", 32'(st_o[0]), 32'(ST_LOCK));
        chk("p1.f3.dut2", 32'(st_o[2]), 32'(ST_LOCK));

        // Missed sync words: flywheel, recovery, then loss of lock
        send_frame(8'h00, 0, FL);
        chk("p2.miss1.dut0", 32'(st_o[0]), 32'(ST_FLYWHEEL));
        chk("p2.miss1.sync0", 32'(sync_o[0]), 32'd1);
        chk("p2.miss1.dut2", 32'(st_o[2]), 32'(ST_HUNT));
        chk("p2.miss1.loss2", 32'(loss_o[2]), 32'd1);
        send_frame(SW, 0, FL);
        chk("p2.recover.dut0", 32'(st_o[0]), 32'(ST_LOCK));
        send_frame(8'h00, 0, FL);
        chk("p2.miss2a.dut0", 32'(st_o[0]), 32'(ST_FLYWHEEL));
        send_frame(8'h00, 0, FL);
        chk("p2.miss2b.dut0", 32'(st_o[0]), 32'(ST_HUNT));
        chk("p2.miss2b.loss0", 32'(loss_o[0]), 32'd1);

        // Reset mid-frame while locked, then re-acquire
        send_frame(SW, 0, FL);
        send_frame(SW, 0, FL);
        chk("p5.relock.dut0", 32'(st_o[0]), 32'(ST_LOCK));
        send_frame(SW, 0, 30);
        async_reset_check();
        send_frame(SW, 0, FL);
        chk("p5.f1.dut0", 32'(st_o[0]), 32'(ST_VERIFY));
        send_frame(SW, 0, FL);
        chk("p5.f2.dut0", 32'(st_o[0]), 32'(ST_LOCK));

        // Error-tolerant match: one bit off accepted, two bits off rejected
        async_reset_check();
        send_frame(8'h7F, 0, FL);
        chk("p3.f1.dut1", 32'(st_o[1]), 32'(ST_VERIFY));
        send_frame(8'h7F, 0, FL);
        chk("p3.f2.dut1", 32'(st_o[1]), 32'(ST_LOCK));
        chk("p3.f2.dut0", 32'(st_o[0]), 32'(ST_HUNT));
        send_frame(8'h7F, 0, FL);
        chk("p3.f3.dut1", 32'(st_o[1]), 32'(ST_LOCK));
        send_frame(8'h7D, 0, FL);
        chk("p3.bad1.dut1", 32'(st_o[1]), 32'(ST_FLYWHEEL));
        send_frame(8'h7D, 0, FL);
        chk("p3.bad2.dut1", 32'(st_o[1]), 32'(ST_HUNT));
        chk("p3.bad2.loss1", 32'(loss_o[1]), 32'd1);

        // Gapped data_valid
        async_reset_check();
        send_frame(SW, 50, FL);
        chk("p4.f1.dut0", 32'(st_o[0]), 32'(ST_VERIFY));
        send_frame(SW, 50, FL);
        chk("p4.f2.dut0", 32'(st_o[0]), 32'(ST_LOCK));
        send_frame(SW, 50, FL);
        send_frame(SW, 50, FL);
        chk("p4.f4.dut0", 32'(st_o[0]), 32'(ST_LOCK));
        chk("p4.f4.dut2", 32'(st_o[2]), 32'(ST_LOCK));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
